// File: rtl/mdu_iter_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   mdu_op_e     : func3 encodings of the M-extension operations
//   mdu_state_e  : FSM states of mdu_iter
//   MDU_FUNCT7   : funct7 value the decoder matches to raise start
//   id_ex_mdu_t  : M-extension slice of the ID/EX pipeline register
// Helper functions report which operands an operation treats as signed.
package mdu_iter_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

    typedef struct packed {
        logic       is_mdu;
        logic [2:0] func3;
        logic [4:0] rd;
    } id_ex_mdu_t;

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic mdu_a_signed(input logic [2:0] f);
        return (f == MDU_MULH) || (f == MDU_MULHSU) || (f == MDU_DIV) || (f == MDU_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM (MULHSU treats rs2 as unsigned).
    function automatic logic mdu_b_signed(input logic [2:0] f);
        return (f == MDU_MULH) || (f == MDU_DIV) || (f == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_sign_fix.sv
// Combinational sign handling around the unsigned iterative core.
//   Prep side : op, op_a, op_b -> mag_a, mag_b (absolute values of the
//               operands the op treats as signed), neg_main (product or
//               quotient must be negated), neg_rem (remainder must be negated).
//   Fix side  : fix_op, fix_neg_main, fix_neg_rem, acc (hi:lo core register)
//               -> fix_result, the architecturally visible result.
module mdu_sign_fix
    import mdu_iter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic [DATA_W-1:0]   mag_a,
    output logic [DATA_W-1:0]   mag_b,
    output logic                neg_main,
    output logic                neg_rem,
    input  logic [2:0]          fix_op,
    input  logic                fix_neg_main,
    input  logic                fix_neg_rem,
    input  logic [2*DATA_W-1:0] acc,
    output logic [DATA_W-1:0]   fix_result
);

    logic                a_neg_s;
    logic                b_neg_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   quot_s;
    logic [DATA_W-1:0]   rem_s;

    // Operand magnitudes and the sign the final result must carry.
    always_comb begin
        a_neg_s  = mdu_a_signed(op) && op_a[DATA_W-1];
        b_neg_s  = mdu_b_signed(op) && op_b[DATA_W-1];
        mag_a    = a_neg_s ? ({DATA_W{1'b0}} - op_a) : op_a;
        mag_b    = b_neg_s ? ({DATA_W{1'b0}} - op_b) : op_b;
        neg_main = a_neg_s ^ b_neg_s;
        // Remainder sign follows the dividend.
        neg_rem  = a_neg_s;
    end

    // Two's-complement correction of the finished magnitude and half select.
    always_comb begin
        // Negating the full double-width product keeps both halves consistent.
        prod_s = fix_neg_main ? ({(2*DATA_W){1'b0}} - acc) : acc;
        quot_s = fix_neg_main ? ({DATA_W{1'b0}} - acc[DATA_W-1:0]) : acc[DATA_W-1:0];
        rem_s  = fix_neg_rem ? ({DATA_W{1'b0}} - acc[2*DATA_W-1:DATA_W])
                             : acc[2*DATA_W-1:DATA_W];
        case (fix_op)
            MDU_MUL:                          fix_result = prod_s[DATA_W-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_result = prod_s[2*DATA_W-1:DATA_W];
            MDU_DIV, MDU_DIVU:                fix_result = quot_s;
            MDU_REM, MDU_REMU:                fix_result = rem_s;
            default:                          fix_result = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit for the EX stage.
//   clk, reset         : rising-edge clock, asynchronous active-high reset
//   start, func3       : M-op present in EX this cycle and its func3 code
//   op_a, op_b, rd_in  : forwarded rs1/rs2 and destination register
//   flush              : pipeline flush, aborts any operation in progress
//   stall_req          : holds PC, IF/ID and ID/EX while the unit computes
//   busy               : unit is not idle
//   done               : one-cycle pulse, result/rd_out valid
//   result, rd_out     : operation result and its destination register
// Multiply is one shift-add step per cycle, divide one restoring step per
// cycle, both on magnitudes; signs are applied in FIX. Divide-by-zero and
// signed overflow bypass the iteration and complete the cycle after start.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RF_ADDRESS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            func3,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic [RF_ADDRESS-1:0] rd_in,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic [RF_ADDRESS-1:0] rd_out
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    mdu_state_e            state_r;
    mdu_state_e            state_next_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [2:0]            op_r;
    logic [RF_ADDRESS-1:0] rd_lat_r;
    logic [DATA_W-1:0]     opnd_r;
    logic [2*DATA_W-1:0]   acc_r;
    logic                  neg_main_r;
    logic                  neg_rem_r;

    logic                  accept_s;
    logic                  div_zero_s;
    logic                  ovf_s;
    logic                  fast_s;
    logic [DATA_W-1:0]     fast_res_s;
    logic [DATA_W-1:0]     mag_a_s;
    logic [DATA_W-1:0]     mag_b_s;
    logic                  neg_main_s;
    logic                  neg_rem_s;
    logic [DATA_W-1:0]     fix_result_s;
    logic [DATA_W:0]       mul_sum_s;
    logic [DATA_W:0]       rem_sh_s;
    logic [DATA_W:0]       diff_s;
    logic [2*DATA_W-1:0]   acc_step_s;

    mdu_sign_fix #(
        .DATA_W (DATA_W)
    ) u_sign_fix (
        .op           (func3),
        .op_a         (op_a),
        .op_b         (op_b),
        .mag_a        (mag_a_s),
        .mag_b        (mag_b_s),
        .neg_main     (neg_main_s),
        .neg_rem      (neg_rem_s),
        .fix_op       (op_r),
        .fix_neg_main (neg_main_r),
        .fix_neg_rem  (neg_rem_r),
        .acc          (acc_r),
        .fix_result   (fix_result_s)
    );

    assign accept_s  = (state_r == MDU_IDLE) && start && !flush;
    assign stall_req = (state_r == MDU_CALC) || (state_r == MDU_FIX) || accept_s;
    assign busy      = (state_r != MDU_IDLE);
    assign done      = (state_r == MDU_DONE);

    // Special-case detection and results for the single-cycle fast path.
    always_comb begin
        div_zero_s = func3[2] && (op_b == {DATA_W{1'b0}});
        // Only DIV/REM (func3[0]==0 within the divide group) are signed.
        ovf_s      = func3[2] && !func3[0] && (op_a == MOST_NEG) && (op_b == {DATA_W{1'b1}});
        fast_s     = div_zero_s || ovf_s;
        if (div_zero_s) begin
            fast_res_s = func3[1] ? op_a : {DATA_W{1'b1}};
        end else if (ovf_s) begin
            fast_res_s = func3[1] ? {DATA_W{1'b0}} : op_a;
        end else begin
            fast_res_s = {DATA_W{1'b0}};
        end
    end

    // One multiply or divide iteration on the hi:lo accumulator.
    always_comb begin
        // Multiply: multiplier sits in lo and shifts out; partial sum grows in hi.
        mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]}
                  + (acc_r[0] ? {1'b0, opnd_r} : {(DATA_W+1){1'b0}});
        // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
        rem_sh_s  = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
        diff_s    = rem_sh_s - {1'b0, opnd_r};
        if (op_r[2]) begin
            if (diff_s[DATA_W]) begin
                acc_step_s = {rem_sh_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
            end else begin
                acc_step_s = {diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[DATA_W-1:1]};
        end
    end

    // Next-state logic; flush outranks everything else.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MDU_IDLE: begin
                if (accept_s) begin
                    state_next_s = fast_s ? MDU_DONE : MDU_CALC;
                end else begin
                    state_next_s = MDU_IDLE;
                end
            end
            MDU_CALC: begin
                if (flush) begin
                    state_next_s = MDU_IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    state_next_s = MDU_FIX;
                end else begin
                    state_next_s = MDU_CALC;
                end
            end
            MDU_FIX: begin
                if (flush) begin
                    state_next_s = MDU_IDLE;
                end else begin
                    state_next_s = MDU_DONE;
                end
            end
            MDU_DONE: state_next_s = MDU_IDLE;
            default:  state_next_s = MDU_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= MDU_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture at accept and iteration of the core registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            op_r       <= 3'd0;
            rd_lat_r   <= {RF_ADDRESS{1'b0}};
            opnd_r     <= {DATA_W{1'b0}};
            acc_r      <= {(2*DATA_W){1'b0}};
            neg_main_r <= 1'b0;
            neg_rem_r  <= 1'b0;
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    if (accept_s) begin
                        op_r       <= func3;
                        rd_lat_r   <= rd_in;
                        neg_main_r <= neg_main_s;
                        neg_rem_r  <= neg_rem_s;
                        cnt_r      <= CNT_W'(DATA_W);
                        if (func3[2]) begin
                            acc_r  <= {{DATA_W{1'b0}}, mag_a_s};
                            opnd_r <= mag_b_s;
                        end else begin
                            acc_r  <= {{DATA_W{1'b0}}, mag_b_s};
                            opnd_r <= mag_a_s;
                        end
                    end
                end
                MDU_CALC: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result and destination register; they hold between operations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= {DATA_W{1'b0}};
            rd_out <= {RF_ADDRESS{1'b0}};
        end else if (accept_s && fast_s) begin
            result <= fast_res_s;
            rd_out <= rd_in;
        end else if ((state_r == MDU_FIX) && !flush) begin
            result <= fix_result_s;
            rd_out <= rd_lat_r;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_chk  = 0;
    int n_pass = 0;

    mdu_iter #(.DATA_W(32), .RF_ADDRESS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .func3     (func3),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // RV32M semantics in plain 64-bit / 32-bit arithmetic.
    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sub, p;
        logic [63:0]        up;
        logic signed [31:0] a32, b32, q;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        sub = {32'd0, b};
        a32 = a;
        b32 = b;
        case (f)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * sub; return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = a32 / b32; return q;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = a32 % b32; return q;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Transaction-level model: cycles since accept, pending result, last result.
    logic        m_active = 1'b0;
    int          m_k      = 0;
    int          m_lat    = 0;
    logic [31:0] m_res_pend = 32'd0;
    logic [4:0]  m_rd_pend  = 5'd0;
    logic [31:0] m_res    = 32'd0;
    logic [4:0]  m_rd     = 5'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_res    <= 32'd0;
            m_rd     <= 5'd0;
        end else if (flush) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active   <= 1'b1;
                m_k        <= 1;
                m_lat      <= ref_lat(func3, op_a, op_b);
                m_res_pend <= ref_mdu(func3, op_a, op_b);
                m_rd_pend  <= rd_in;
                if (ref_lat(func3, op_a, op_b) == 1) begin
                    m_res <= ref_mdu(func3, op_a, op_b);
                    m_rd  <= rd_in;
                end
            end
        end else if (m_k == m_lat) begin
            m_active <= 1'b0;
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_lat) begin
                m_res <= m_res_pend;
                m_rd  <= m_rd_pend;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("cyc_done",   {63'd0, done},      {63'd0, m_active && (m_k == m_lat)});
        chk("cyc_busy",   {63'd0, busy},      {63'd0, m_active});
        chk("cyc_stall",  {63'd0, stall_req},
            {63'd0, m_active ? (m_k < m_lat) : (start && !flush && !reset)});
        chk("cyc_result", {32'd0, result},    {32'd0, m_res});
        chk("cyc_rd_out", {59'd0, rd_out},    {59'd0, m_rd});
    end

    // Issue one op, optionally holding start high with garbage operands.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] req,
                          input int req_lat, input int hold);
        int  n;
        int  stall_cnt;
        bit  seen;
        chk({name, "_model"}, {32'd0, ref_mdu(f, a, b)}, {32'd0, req});
        @(posedge clk); #1;
        start = 1'b1; func3 = f; op_a = a; op_b = b; rd_in = rd;
        @(negedge clk);
        stall_cnt = stall_req ? 1 : 0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            n++;
            if (n <= hold) begin
                func3 = f ^ 3'd1; op_a = ~a; op_b = a ^ b; rd_in = ~rd;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (stall_req) stall_cnt++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({name, "_latency"}, n, req_lat);
            chk({name, "_stall_cycles"}, stall_cnt, req_lat);
            chk({name, "_result"}, {32'd0, result}, {32'd0, req});
            chk({name, "_rd_out"}, {59'd0, rd_out}, {59'd0, rd});
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; func3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        rd_in = 5'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;

        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 34, 0);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34, 0);
        run_op("mulh",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 34, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 34, 0);
        run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD, 34, 0);
        run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 34, 0);
        run_op("divu",   3'd5, 32'd100,        32'd7,         5'd7,  32'd14,        34, 0);
        run_op("remu",   3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         34, 0);
        run_op("div0",   3'd4, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1,  0);
        run_op("rem0",   3'd6, 32'd5,          32'd0,         5'd10, 32'd5,         1,  0);
        run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1,  0);
        run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1,  0);

        // Flush a DIVU at cycle 10: no done pulse, unit idle next cycle.
        @(posedge clk); #1;
        start = 1'b1; func3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_rd_kept", {59'd0, rd_out}, {59'd0, 5'd12});
        @(posedge clk);
        run_op("after_flush", 3'd5, 32'd1000, 32'd3, 5'd17, 32'd333, 34, 0);

        // start held high while busy must not disturb the in-flight op.
        run_op("mul_hold", 3'd0, 32'd12345, 32'd678, 5'd20, 32'd8369910, 34, 20);

        // Asynchronous reset between edges in the middle of a MUL.
        @(posedge clk); #1;
        start = 1'b1; func3 = 3'd0; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd21;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_result", {32'd0, result}, 64'd0);
        chk("areset_rd_out", {59'd0, rd_out}, 64'd0);
        chk("areset_busy",   {63'd0, busy}, 64'd0);
        chk("areset_done",   {63'd0, done}, 64'd0);
        chk("areset_stall",  {63'd0, stall_req}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op("after_reset", 3'd6, 32'hFFFF_FF9C, 32'd7, 5'd22, 32'hFFFF_FFFE, 34, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
